// File: rtl/dmem_access_unit.sv
// Load/store front-end between the memory stage and a word-wide simple-dual-port BRAM.
// Sub-word stores are done as read-modify-write because the BRAM has no byte enables.
module dmem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dia,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_dob
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_MERGE} state_t;

  state_t                  state, state_nx;
  logic                    accept;
  logic                    req_err;
  logic                    is_store_word;
  logic [ADDR_WIDTH-1:0]   word_addr;

  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [1:0]              lat_off;
  logic [2:0]              lat_f3;
  logic [15:0]             lat_wdata;

  logic [7:0]              sel_byte;
  logic [15:0]             sel_half;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   merged;

  assign word_addr     = req_addr[ADDR_WIDTH+1:2];
  assign is_store_word = req_we && (req_funct3 == F3_W);

  // Alignment and legality; unsigned variants exist only for loads.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = req_addr[0];
      F3_W:    req_err = |req_addr[1:0];
      F3_BU:   req_err = req_we;
      F3_HU:   req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    case (lat_off)
      2'd0: sel_byte = ram_dob[7:0];
      2'd1: sel_byte = ram_dob[15:8];
      2'd2: sel_byte = ram_dob[23:16];
      2'd3: sel_byte = ram_dob[31:24];
    endcase
    sel_half = lat_off[1] ? ram_dob[31:16] : ram_dob[15:0];
    case (lat_f3)
      F3_B:    load_val = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_val = {24'h0, sel_byte};
      F3_H:    load_val = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_val = {16'h0, sel_half};
      default: load_val = ram_dob;
    endcase
  end

  always_comb begin
    merged = ram_dob;
    if (lat_f3 == F3_B) begin
      case (lat_off)
        2'd0: merged[7:0]   = lat_wdata[7:0];
        2'd1: merged[15:8]  = lat_wdata[7:0];
        2'd2: merged[23:16] = lat_wdata[7:0];
        2'd3: merged[31:24] = lat_wdata[7:0];
      endcase
    end else if (lat_off[1]) begin
      merged[31:16] = lat_wdata;
    end else begin
      merged[15:0] = lat_wdata;
    end
  end

  always_comb begin
    state_nx  = state;
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dia   = '0;
    ram_enb   = 1'b0;
    ram_addrb = '0;
    req_ready = (state == IDLE) && !rst;
    accept    = req_valid && req_ready;
    case (state)
      IDLE: begin
        if (accept && !req_err) begin
          if (is_store_word) begin
            ram_ena   = 1'b1;
            ram_wea   = 1'b1;
            ram_addra = word_addr;
            ram_dia   = req_wdata;
          end else begin
            ram_enb   = 1'b1;
            ram_addrb = word_addr;
            state_nx  = req_we ? RMW_MERGE : LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: state_nx = IDLE;
      RMW_MERGE: begin
        ram_ena   = 1'b1;
        ram_wea   = 1'b1;
        ram_addra = lat_addr;
        ram_dia   = merged;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset kills any in-flight write, including the RMW write-back.
    if (rst) begin
      state_nx = IDLE;
      ram_ena  = 1'b0;
      ram_wea  = 1'b0;
      ram_enb  = 1'b0;
      ram_addra = '0;
      ram_addrb = '0;
      ram_dia   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      resp_valid <= 1'b0;
      if (accept && (req_err || is_store_word)) begin
        resp_valid <= 1'b1;
        resp_err   <= req_err;
        resp_rdata <= '0;
      end
      if (state == LOAD_WAIT) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
        resp_rdata <= load_val;
      end
      if (state == RMW_MERGE) begin
        resp_valid <= 1'b1;
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_addr  <= word_addr;
      lat_off   <= req_addr[1:0];
      lat_f3    <= req_funct3;
      lat_wdata <= req_wdata[15:0];
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural BRAM (write port A, registered read port B).
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_ena, ram_wea, ram_enb;
  logic [9:0]  ram_addra, ram_addrb;
  logic [31:0] ram_dia, ram_dob;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  logic        c0_ena, c0_wea, c0_enb, c1_ready, c1_ena, c1_wea, c1_enb;
  logic [9:0]  c0_addra, c0_addrb, c1_addra;
  logic [31:0] c0_dia, c1_dia;
  int          lat;
  logic [31:0] rd;
  logic        er;

  dmem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    ram_dob = '0;
  end

  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  // One request from accept to response; captures RAM-side activity in cycles 0 and 1.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                      input logic [31:0] wd);
    issue(we, f3, addr, wd);
    #1;
    c0_ena = ram_ena; c0_wea = ram_wea; c0_enb = ram_enb;
    c0_addra = ram_addra; c0_addrb = ram_addrb; c0_dia = ram_dia;
    step();
    req_valid = 1'b0;
    #1;
    c1_ready = req_ready; c1_ena = ram_ena; c1_wea = ram_wea; c1_enb = ram_enb;
    c1_addra = ram_addra; c1_dia = ram_dia;
    lat = 1;
    while (!resp_valid && lat < 6) begin
      step();
      lat++;
    end
    if (!resp_valid) lat = 99;
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic expect_resp(input string tag, input int elat, input logic [31:0] erd,
                             input logic eer);
    check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
    check_eq({tag, "_rdata"}, rd, erd);
    check_eq({tag, "_err"}, 32'(er), 32'(eer));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (3) step();

    // A request presented during reset must not touch the RAM.
    issue(1'b1, 3'b010, 12'h040, 32'hFFFF_FFFF);
    #1;
    check_eq("rst_ena", 32'(ram_ena), 0);
    check_eq("rst_wea", 32'(ram_wea), 0);
    check_eq("rst_enb", 32'(ram_enb), 0);
    check_eq("rst_ready", 32'(req_ready), 0);
    check_eq("rst_resp_valid", 32'(resp_valid), 0);
    check_eq("rst_resp_rdata", resp_rdata, 0);
    check_eq("rst_resp_err", 32'(resp_err), 0);
    req_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(req_ready), 1);

    // SW then LW
    xact(1'b1, 3'b010, 12'h010, 32'hDEAD_BEEF);
    check_eq("sw_c0_ena", 32'(c0_ena), 1);
    check_eq("sw_c0_wea", 32'(c0_wea), 1);
    check_eq("sw_c0_addra", 32'(c0_addra), 32'h4);
    check_eq("sw_c0_dia", c0_dia, 32'hDEAD_BEEF);
    check_eq("sw_c0_enb", 32'(c0_enb), 0);
    expect_resp("sw", 1, 32'h0, 1'b0);

    xact(1'b0, 3'b010, 12'h010, 32'h0);
    check_eq("lw_c0_enb", 32'(c0_enb), 1);
    check_eq("lw_c0_addrb", 32'(c0_addrb), 32'h4);
    check_eq("lw_c0_ena", 32'(c0_ena), 0);
    check_eq("lw_c1_ready", 32'(c1_ready), 0);
    expect_resp("lw", 2, 32'hDEAD_BEEF, 1'b0);

    // SB via read-modify-write
    xact(1'b1, 3'b000, 12'h011, 32'h1234_56AA);
    check_eq("sb_c0_enb", 32'(c0_enb), 1);
    check_eq("sb_c0_wea", 32'(c0_wea), 0);
    check_eq("sb_c1_ready", 32'(c1_ready), 0);
    check_eq("sb_c1_wea", 32'(c1_wea), 1);
    check_eq("sb_c1_ena", 32'(c1_ena), 1);
    check_eq("sb_c1_addra", 32'(c1_addra), 32'h4);
    check_eq("sb_c1_dia", c1_dia, 32'hDEAD_AAEF);
    expect_resp("sb", 2, 32'h0, 1'b0);
    xact(1'b0, 3'b000, 12'h011, 32'h0);
    expect_resp("lb", 2, 32'hFFFF_FFAA, 1'b0);
    xact(1'b0, 3'b100, 12'h011, 32'h0);
    expect_resp("lbu", 2, 32'h0000_00AA, 1'b0);

    // SH upper half, then halfword and byte loads
    xact(1'b1, 3'b001, 12'h012, 32'h0000_1234);
    check_eq("sh_c1_dia", c1_dia, 32'h1234_AAEF);
    expect_resp("sh", 2, 32'h0, 1'b0);
    xact(1'b0, 3'b101, 12'h012, 32'h0);
    expect_resp("lhu", 2, 32'h0000_1234, 1'b0);
    xact(1'b0, 3'b001, 12'h010, 32'h0);
    expect_resp("lh", 2, 32'hFFFF_AAEF, 1'b0);
    xact(1'b0, 3'b000, 12'h013, 32'h0);
    expect_resp("lb_pos", 2, 32'h0000_0012, 1'b0);

    // Errors: misaligned LW, misaligned SH, store with BU funct3, illegal funct3
    xact(1'b0, 3'b010, 12'h013, 32'h0);
    check_eq("err_lw_en", 32'(c0_ena | c0_wea | c0_enb | c1_ena | c1_wea | c1_enb), 0);
    expect_resp("err_lw", 1, 32'h0, 1'b1);
    xact(1'b1, 3'b001, 12'h011, 32'hFFFF_FFFF);
    check_eq("err_sh_en", 32'(c0_ena | c0_wea | c0_enb | c1_ena | c1_wea | c1_enb), 0);
    expect_resp("err_sh", 1, 32'h0, 1'b1);
    xact(1'b1, 3'b100, 12'h014, 32'hFFFF_FFFF);
    check_eq("err_sbu_en", 32'(c0_ena | c0_wea | c0_enb | c1_ena | c1_wea | c1_enb), 0);
    expect_resp("err_sbu", 1, 32'h0, 1'b1);
    xact(1'b0, 3'b011, 12'h010, 32'h0);
    check_eq("err_f3_en", 32'(c0_ena | c0_wea | c0_enb | c1_ena | c1_wea | c1_enb), 0);
    expect_resp("err_f3", 1, 32'h0, 1'b1);
    xact(1'b0, 3'b100, 12'h010, 32'h0);
    expect_resp("lbu_after_err", 2, 32'h0000_00EF, 1'b0);
    xact(1'b0, 3'b010, 12'h040, 32'h0);
    expect_resp("lw_rst_store", 2, 32'h0, 1'b0);

    // Back-to-back: SW, LW next cycle, SW alongside the load response
    issue(1'b1, 3'b010, 12'h020, 32'h1111_1111);
    #1;
    check_eq("b2b_sw1_ena", 32'(ram_ena), 1);
    check_eq("b2b_sw1_addra", 32'(ram_addra), 32'h8);
    step();
    issue(1'b0, 3'b010, 12'h020, 32'h0);
    check_eq("b2b_sw1_resp", 32'(resp_valid), 1);
    check_eq("b2b_lw_ready", 32'(req_ready), 1);
    #1;
    check_eq("b2b_lw_enb", 32'(ram_enb), 1);
    check_eq("b2b_lw_addrb", 32'(ram_addrb), 32'h8);
    step();
    req_valid = 1'b0;
    check_eq("b2b_wait_ready", 32'(req_ready), 0);
    check_eq("b2b_wait_valid", 32'(resp_valid), 0);
    step();
    check_eq("b2b_lw_resp", 32'(resp_valid), 1);
    check_eq("b2b_lw_rdata", resp_rdata, 32'h1111_1111);
    issue(1'b1, 3'b010, 12'h024, 32'h2222_2222);
    #1;
    check_eq("b2b_sw2_ready", 32'(req_ready), 1);
    check_eq("b2b_sw2_ena", 32'(ram_ena), 1);
    check_eq("b2b_sw2_addra", 32'(ram_addra), 32'h9);
    step();
    req_valid = 1'b0;
    check_eq("b2b_sw2_resp", 32'(resp_valid), 1);
    check_eq("b2b_sw2_rdata", resp_rdata, 32'h0);
    xact(1'b0, 3'b010, 12'h024, 32'h0);
    expect_resp("b2b_lw2", 2, 32'h2222_2222, 1'b0);

    // Reset in RMW_MERGE aborts the write-back
    xact(1'b1, 3'b010, 12'h030, 32'hCAFE_F00D);
    expect_resp("abort_sw", 1, 32'h0, 1'b0);
    issue(1'b1, 3'b000, 12'h030, 32'h0000_0055);
    #1;
    check_eq("abort_sb_enb", 32'(ram_enb), 1);
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("abort_wea", 32'(ram_wea), 0);
    check_eq("abort_ena", 32'(ram_ena), 0);
    check_eq("abort_ready", 32'(req_ready), 0);
    step();
    check_eq("abort_no_resp", 32'(resp_valid), 0);
    rst = 1'b0;
    #1;
    check_eq("abort_ready_after", 32'(req_ready), 1);
    xact(1'b0, 3'b010, 12'h030, 32'h0);
    expect_resp("abort_lw", 2, 32'hCAFE_F00D, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
